// File: rtl/lvt_distributed_multi_port_ram.sv
// Multi-write/multi-read distributed RAM: one bank per write port, a live-value table
// picks the bank holding the newest value; includes a post-reset init sweep of bank0/LVT.
module lvt_distributed_multi_port_ram #(
    parameter int ENTRY_NUM      = 64,
    parameter int ENTRY_BIT_SIZE = 32,
    parameter int WRITE_NUM      = 2,
    parameter int READ_NUM       = 2,
    parameter int READ_BYPASS    = 0,
    parameter logic [ENTRY_BIT_SIZE-1:0] INIT_VALUE = '0,
    localparam int AW = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1,
    localparam int LW = (WRITE_NUM > 1) ? $clog2(WRITE_NUM) : 1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [WRITE_NUM-1:0]                     we_i,
    input  logic [WRITE_NUM-1:0][AW-1:0]             wa_i,
    input  logic [WRITE_NUM-1:0][ENTRY_BIT_SIZE-1:0] wv_i,
    input  logic [READ_NUM-1:0][AW-1:0]              ra_i,
    output logic [READ_NUM-1:0][ENTRY_BIT_SIZE-1:0]  rv_o,
    output logic                                     busy_o,
    output logic                                     conflict_o
);

    localparam logic [AW:0]   ENTRY_LIM = (AW+1)'(ENTRY_NUM);
    localparam logic [AW-1:0] LAST_IDX  = AW'(ENTRY_NUM - 1);

    typedef enum logic {ST_INIT, ST_READY} state_e;

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;

    logic [ENTRY_BIT_SIZE-1:0] bank_q [WRITE_NUM][ENTRY_NUM];
    logic [LW-1:0]             rd_sel [READ_NUM];

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < ENTRY_LIM;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_q <= ST_READY;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                ST_READY: state_q <= ST_READY;
                default: begin
                    state_q <= ST_INIT;
                    busy_q  <= 1'b1;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;

    // Banks carry no reset; the init sweep gives them a defined value instead.
    always_ff @(posedge clk_i) begin
        if (busy_q) begin
            bank_q[0][cnt_q] <= INIT_VALUE;
        end else begin
            for (int p = 0; p < WRITE_NUM; p++) begin
                if (we_i[p] && in_range(wa_i[p]))
                    bank_q[p][wa_i[p]] <= wv_i[p];
            end
        end
    end

    generate
        if (WRITE_NUM > 1) begin : g_lvt
            logic [LW-1:0] lvt_q [ENTRY_NUM];

            // Ascending loop: the highest-index port's update lands last and wins.
            always_ff @(posedge clk_i) begin
                if (busy_q) begin
                    lvt_q[cnt_q] <= '0;
                end else begin
                    for (int p = 0; p < WRITE_NUM; p++) begin
                        if (we_i[p] && in_range(wa_i[p]))
                            lvt_q[wa_i[p]] <= LW'(p);
                    end
                end
            end

            always_comb begin
                for (int r = 0; r < READ_NUM; r++) begin
                    rd_sel[r] = '0;
                    if (in_range(ra_i[r]))
                        rd_sel[r] = lvt_q[ra_i[r]];
                end
            end

            always_comb begin
                conflict_o = 1'b0;
                for (int p = 0; p < WRITE_NUM; p++) begin
                    for (int q = p + 1; q < WRITE_NUM; q++) begin
                        if (we_i[p] && we_i[q] && (wa_i[p] == wa_i[q]))
                            conflict_o = !busy_q;
                    end
                end
            end
        end else begin : g_no_lvt
            always_comb begin
                for (int r = 0; r < READ_NUM; r++)
                    rd_sel[r] = '0;
            end
            assign conflict_o = 1'b0;
        end
    endgenerate

    always_comb begin
        for (int r = 0; r < READ_NUM; r++) begin
            rv_o[r] = '0;
            if (in_range(ra_i[r]))
                rv_o[r] = bank_q[rd_sel[r]][ra_i[r]];
            if (READ_BYPASS != 0 && !busy_q) begin
                for (int p = 0; p < WRITE_NUM; p++) begin
                    if (we_i[p] && in_range(wa_i[p]) && (wa_i[p] == ra_i[r]))
                        rv_o[r] = wv_i[p];
                end
            end
        end
    end

endmodule
